// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths and header field positions for the router register stage
package router_pkg;

    // Default byte width of the router datapath.
    localparam int DATA_WIDTH = 8;

    // Destination address that has no output FIFO; such headers are never latched.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Header byte layout: {len, addr}.
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = DATA_WIDTH - 1;

endpackage

// File: rtl/router_parity_chk.sv
// rtl/router_parity_chk.sv - running parity, received parity and mismatch flag (ROUTER_REG_ERR_CNT_EN adds err_rise_o)
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic          clock_i,
    input  logic          resetn_i,
    input  logic          detect_add_i,
    input  logic          lfd_state_i,
    input  logic          ld_state_i,
    input  logic          full_state_i,
    input  logic          pkt_valid_i,
    input  logic [DW-1:0] hdr_i,
    input  logic [DW-1:0] data_in_i,
    input  logic          parity_done_i,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic          err_rise_o,
`endif
    output logic          err_o
);

    logic [DW-1:0] int_par_q, int_par_d;
    logic [DW-1:0] pkt_par_q, pkt_par_d;
    logic          err_q, err_d;

    // Next-state for the running parity, the captured parity byte and the error flag.
    always_comb begin
        int_par_d = int_par_q;
        pkt_par_d = pkt_par_q;
        err_d     = err_q;

        // A new packet starts from zero; the header joins the parity when it is forwarded,
        // payload only while the byte is really accepted (not stalled in FIFO_FULL_STATE).
        if (detect_add_i) begin
            int_par_d = '0;
        end else if (lfd_state_i) begin
            int_par_d = int_par_q ^ hdr_i;
        end else if (ld_state_i && pkt_valid_i && !full_state_i) begin
            int_par_d = int_par_q ^ data_in_i;
        end

        // The byte seen with pkt_valid low is the sender's parity.
        if (ld_state_i && !pkt_valid_i) begin
            pkt_par_d = data_in_i;
        end

        // Compare only once the parity byte has landed; keep the verdict until the next header.
        if (detect_add_i) begin
            err_d = 1'b0;
        end else if (parity_done_i) begin
            err_d = (int_par_q != pkt_par_q);
        end
    end

    // Parity and error registers.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            int_par_q <= '0;
            pkt_par_q <= '0;
            err_q     <= 1'b0;
        end else begin
            int_par_q <= int_par_d;
            pkt_par_q <= pkt_par_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
    // Lets the counter step on the same edge the error appears.
    assign err_rise_o = err_d & ~err_q;
`endif

endmodule

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath register stage: header latch, full-byte hold, flags (ROUTER_REG_ERR_CNT_EN adds err_count)
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  full_state,
    input  logic                  laf_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]            err_count,
`endif
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0] ffb_q, ffb_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;

    // Next-state for the header latch, output byte, full-hold byte and FSM return flags.
    always_comb begin
        hdr_d           = hdr_q;
        dout_d          = dout_q;
        ffb_d           = ffb_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;

        // Headers aimed at the nonexistent port are ignored so the last good header survives.
        if (detect_add && pkt_valid &&
            (data_in[HDR_ADDR_MSB:HDR_ADDR_LSB] != ADDR_INVALID)) begin
            hdr_d = data_in;
        end

        // Header goes out first; a byte arriving against a full FIFO is parked in ffb
        // and replayed once the FSM reaches LOAD_AFTER_FULL.
        if (lfd_state) begin
            dout_d = hdr_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            ffb_d = data_in;
        end else if (laf_state) begin
            dout_d = ffb_q;
        end

        // Parity byte is taken either directly or, if it was parked, when it is replayed.
        if (detect_add) begin
            parity_done_d = 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end

        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end
    end

    // Datapath and flag registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            hdr_q           <= '0;
            dout_q          <= '0;
            ffb_q           <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            hdr_q           <= hdr_d;
            dout_q          <= dout_d;
            ffb_q           <= ffb_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

`ifdef ROUTER_REG_ERR_CNT_EN
    logic       err_rise;
    logic [7:0] err_count_q, err_count_d;
`endif

    router_parity_chk #(
        .DW (DATA_WIDTH)
    ) u_parity_chk (
        .clock_i       (clock),
        .resetn_i      (resetn),
        .detect_add_i  (detect_add),
        .lfd_state_i   (lfd_state),
        .ld_state_i    (ld_state),
        .full_state_i  (full_state),
        .pkt_valid_i   (pkt_valid),
        .hdr_i         (hdr_q),
        .data_in_i     (data_in),
        .parity_done_i (parity_done_q),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_rise_o    (err_rise),
`endif
        .err_o         (err)
    );

`ifdef ROUTER_REG_ERR_CNT_EN
    // One count per packet that goes bad; sticks at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        if (err_rise && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - directed bench for router_reg with a behavioural reference model
module tb_router_reg;

    typedef enum int {S_IDLE, S_DA, S_LFD, S_LD, S_FULL, S_LAF, S_CHK} st_e;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       detect_add = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       full_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    always #5 clock = ~clock;

    router_reg #(.DATA_WIDTH(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .full_state    (full_state),
        .laf_state     (laf_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_count     (err_count),
`endif
        .dout          (dout)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the stage must hold after each clock.
    logic [7:0] m_dout = 8'h00, m_hdr = 8'h00, m_ffb = 8'h00;
    logic [7:0] m_run = 8'h00, m_par = 8'h00;
    logic       m_pd = 1'b0, m_lpv = 1'b0, m_err = 1'b0;
    int         m_bad = 0;
    logic       chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the model from the rules with the inputs now applied.
    task automatic cyc();
        logic [7:0] nd, nh, nf, nr, np;
        logic       npd, nlpv, nerr;
        int         nbad;
        nd = m_dout; nh = m_hdr; nf = m_ffb; nr = m_run; np = m_par;
        npd = m_pd; nlpv = m_lpv; nerr = m_err; nbad = m_bad;
        if (!resetn) begin
            nd = 0; nh = 0; nf = 0; nr = 0; np = 0;
            npd = 0; nlpv = 0; nerr = 0; nbad = 0;
        end else begin
            if (detect_add && pkt_valid && (data_in % 4 != 3)) nh = data_in;
            if (lfd_state)                    nd = m_hdr;
            else if (ld_state && !fifo_full)  nd = data_in;
            else if (ld_state)                nf = data_in;
            else if (laf_state)               nd = m_ffb;
            if (detect_add)                   nr = 0;
            else if (lfd_state)               nr = m_run ^ m_hdr;
            else if (ld_state && pkt_valid && !full_state) nr = m_run ^ data_in;
            if (ld_state && !pkt_valid)       np = data_in;
            if (detect_add) npd = 0;
            else if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && m_lpv && !m_pd)) npd = 1;
            if (rst_int_reg) nlpv = 0;
            else if (ld_state && !pkt_valid) nlpv = 1;
            if (detect_add) nerr = 0;
            else if (m_pd) nerr = (m_run != m_par);
            if (nerr && !m_err && nbad < 255) nbad = nbad + 1;
        end
        @(posedge clock);
        #1;
        m_dout = nd; m_hdr = nh; m_ffb = nf; m_run = nr; m_par = np;
        m_pd = npd; m_lpv = nlpv; m_err = nerr; m_bad = nbad;
        chk_en = 1'b1;
    endtask

    task automatic step(input st_e st, input logic pv, input logic ff, input logic [7:0] d);
        detect_add  = (st == S_DA);
        lfd_state   = (st == S_LFD);
        ld_state    = (st == S_LD);
        full_state  = (st == S_FULL);
        laf_state   = (st == S_LAF);
        rst_int_reg = (st == S_CHK);
        pkt_valid   = pv;
        fifo_full   = ff;
        data_in     = d;
        cyc();
    endtask

    // Every cycle: DUT must agree with the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("dout", dout, m_dout);
            check("parity_done", parity_done, m_pd);
            check("low_pkt_valid", low_pkt_valid, m_lpv);
            check("err", err, m_err);
`ifdef ROUTER_REG_ERR_CNT_EN
            check("err_count", err_count, m_bad);
`endif
        end
    end

    // Three-payload packet with no back-pressure; literal checks pin the model.
    task automatic pkt3(input logic [7:0] h, a, b, c, par, input logic exp_err);
        step(S_DA, 1, 0, h);     check("da_err_clr", err, 0);
        step(S_LFD, 1, 0, a);    check("lfd_dout", dout, h);
        step(S_LD, 1, 0, a);     check("ld0_dout", dout, a);
        step(S_LD, 1, 0, b);     check("ld1_dout", dout, b);
        step(S_LD, 1, 0, c);     check("ld2_dout", dout, c);
        step(S_LD, 0, 0, par);   check("par_dout", dout, par);
                                 check("par_done", parity_done, 1);
        step(S_IDLE, 0, 0, 0);   check("chk_err", err, exp_err);
        step(S_CHK, 0, 0, 0);    check("lpv_clr", low_pkt_valid, 0);
    endtask

    initial begin
        // Reset
        resetn = 1'b0;
        step(S_IDLE, 0, 0, 8'h00);
        check("rst_dout", dout, 0);
        check("rst_flags", {parity_done, low_pkt_valid, err}, 0);
        resetn = 1'b1;
        step(S_IDLE, 0, 0, 8'h00);

        // 1: good packet, 2: bad parity byte
        pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 1'b0);
        pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C, 1'b1);

        // 3: FIFO full as 0x22 arrives
        step(S_DA, 1, 0, 8'h0D);  check("t3_err_clr", err, 0);
        step(S_LFD, 1, 0, 8'h11); check("t3_lfd", dout, 8'h0D);
        step(S_LD, 1, 0, 8'h11);  check("t3_ld0", dout, 8'h11);
        step(S_LD, 1, 1, 8'h22);  check("t3_hold", dout, 8'h11);
        step(S_FULL, 1, 1, 8'h33); check("t3_full_hold", dout, 8'h11);
        step(S_LAF, 1, 0, 8'h33); check("t3_laf", dout, 8'h22);
        step(S_LD, 1, 0, 8'h33);  check("t3_ld2", dout, 8'h33);
        step(S_LD, 0, 0, 8'h0D);  check("t3_pd", parity_done, 1);
        step(S_IDLE, 0, 0, 0);    check("t3_err", err, 0);
        step(S_CHK, 0, 0, 0);

        // 4: parity byte arrives against a full FIFO
        step(S_DA, 1, 0, 8'h09);
        step(S_LFD, 1, 0, 8'h11);
        step(S_LD, 1, 0, 8'h11);
        step(S_LD, 1, 0, 8'h22);
        step(S_LD, 0, 1, 8'h3A);  check("t4_lpv", low_pkt_valid, 1);
                                  check("t4_pd_wait", parity_done, 0);
                                  check("t4_hold", dout, 8'h22);
        step(S_FULL, 0, 1, 8'h3A);
        step(S_LAF, 0, 0, 8'h3A); check("t4_laf", dout, 8'h3A);
                                  check("t4_pd", parity_done, 1);
        step(S_IDLE, 0, 0, 0);    check("t4_err", err, 0);
        step(S_CHK, 0, 0, 0);     check("t4_lpv_clr", low_pkt_valid, 0);

        // 5: address-3 header must not replace the latched header
        step(S_DA, 1, 0, 8'h0F);
        step(S_LFD, 1, 0, 8'h00); check("t5_hdr_kept", dout, 8'h09);
        step(S_IDLE, 0, 0, 0);

        // Two more bad packets for three error events in total
        pkt3(8'h05, 8'hA5, 8'h5A, 8'hFF, 8'h00, 1'b1);
        pkt3(8'h06, 8'h01, 8'h02, 8'h04, 8'h07, 1'b1);
`ifdef ROUTER_REG_ERR_CNT_EN
        check("err_count_3", err_count, 3);
`endif

        // 6: reset after the second payload byte
        step(S_DA, 1, 0, 8'h0D);
        step(S_LFD, 1, 0, 8'h11);
        step(S_LD, 1, 0, 8'h11);
        step(S_LD, 1, 0, 8'h22);  check("t6_pre", dout, 8'h22);
        resetn = 1'b0;
        step(S_LD, 1, 0, 8'h33);  check("t6_dout", dout, 0);
                                  check("t6_flags", {parity_done, low_pkt_valid, err}, 0);
`ifdef ROUTER_REG_ERR_CNT_EN
                                  check("t6_cnt", err_count, 0);
`endif
        resetn = 1'b1;
        step(S_IDLE, 0, 0, 0);
        @(negedge clock);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
